automorph_addr_sequencer: RTL and testbench

//  Sequences the automorphism address generation unit for one rotation batch of an FFT iteration.

---
 rtl/automorph_addr_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_automorph_addr_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/automorph_addr_sequencer.sv
// Automorphism address sequencer.
// Walks rotation r, block index i and word offset w for one rotation batch. It drives the AGU
// inputs and captures the AGU's registered output into a 2-entry buffer. The buffer streams
// downstream with valid/ready.
// Optional build macro: AUTOSEQ_STATS_EN adds the stall_cycles and beat_count statistics ports.
module automorph_addr_sequencer #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MAX_R      = 31,
  parameter int unsigned I_WIDTH    = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4:0]            cfg_num_rot,
  input  logic [CNT_WIDTH-1:0]  cfg_num_i,
  input  logic [CNT_WIDTH-1:0]  cfg_num_words,
  output logic [I_WIDTH-1:0]    agu_i,
  output logic [4:0]            agu_r,
  output logic [ADDR_WIDTH-1:0] agu_addr,
  input  logic [ADDR_WIDTH-1:0] agu_out_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [4:0]            out_r,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
`ifdef AUTOSEQ_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           beat_count
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  // Latched batch configuration
  logic [4:0]           num_rot_q, num_rot_d;
  logic [CNT_WIDTH-1:0] num_i_q, num_i_d;
  logic [CNT_WIDTH-1:0] num_words_q, num_words_d;

  // Loop counters; they are also the AGU inputs
  logic [4:0]           r_q, r_d;
  logic [CNT_WIDTH-1:0] i_q, i_d;
  logic [CNT_WIDTH-1:0] w_q, w_d;

  logic busy_q, busy_d;
  logic done_q, done_d;

  // Beat in flight through the AGU register, with its tags
  logic       inflight_q;
  logic [4:0] tag_r_q;
  logic       tag_last_q;

  // 2-entry output buffer
  logic [ADDR_WIDTH-1:0] buf_addr_q [2];
  logic [4:0]            buf_r_q    [2];
  logic                  buf_last_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            occ_q;

  logic       pop, push, issue;
  logic       at_last_w, at_last_i, at_last_r, last_issue;
  logic       drain_finish, cfg_zero;
  logic [4:0] rot_clamped;
  logic [2:0] credit;

  assign rot_clamped = (32'(cfg_num_rot) > MAX_R) ? 5'(MAX_R) : cfg_num_rot;
  assign cfg_zero    = (rot_clamped == 5'd0) || (cfg_num_i == '0) || (cfg_num_words == '0);

  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q;

  // Issue only if the buffer can still absorb this beat when it leaves the AGU register
  assign credit = {1'b0, occ_q} + {2'b00, inflight_q};
  assign issue  = (state_q == StRun) && (credit <= ({2'b00, pop} + 3'd1));

  assign at_last_w  = (w_q == (num_words_q - CNT_WIDTH'(1)));
  assign at_last_i  = (i_q == (num_i_q - CNT_WIDTH'(1)));
  assign at_last_r  = (r_q == (num_rot_q - 5'd1));
  assign last_issue = at_last_w && at_last_i && at_last_r;

  // The final beat leaves this cycle and nothing remains in the buffer or the AGU
  assign drain_finish = (state_q == StDrain) && !inflight_q &&
                        ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop));

  // Next-state logic for the FSM, the loop counters and busy/done
  always_comb begin
    state_d     = state_q;
    num_rot_d   = num_rot_q;
    num_i_d     = num_i_q;
    num_words_d = num_words_q;
    r_d         = r_q;
    i_d         = i_q;
    w_d         = w_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          num_rot_d   = rot_clamped;
          num_i_d     = cfg_num_i;
          num_words_d = cfg_num_words;
          r_d         = '0;
          i_d         = '0;
          w_d         = '0;
          busy_d      = 1'b1;
          state_d     = cfg_zero ? StDone : StRun;
        end
      end
      StRun: begin
        if (issue) begin
          if (last_issue) begin
            // Hold counters on the final beat so the AGU inputs stay put
            state_d = StDrain;
          end else if (!at_last_w) begin
            w_d = w_q + CNT_WIDTH'(1);
          end else begin
            w_d = '0;
            if (!at_last_i) begin
              i_d = i_q + CNT_WIDTH'(1);
            end else begin
              i_d = '0;
              r_d = r_q + 5'd1;
            end
          end
        end
      end
      StDrain: begin
        if (drain_finish) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        // Still busy only on the empty-batch path, which has not yet pulsed done
        if (busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and AGU tag pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      num_rot_q   <= '0;
      num_i_q     <= '0;
      num_words_q <= '0;
      r_q         <= '0;
      i_q         <= '0;
      w_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
      tag_r_q     <= '0;
      tag_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_rot_q   <= num_rot_d;
      num_i_q     <= num_i_d;
      num_words_q <= num_words_d;
      r_q         <= r_d;
      i_q         <= i_d;
      w_q         <= w_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      inflight_q  <= issue;
      if (issue) begin
        tag_r_q    <= r_q;
        tag_last_q <= at_last_w && at_last_i;
      end
    end
  end

  // Output buffer: push the AGU result, pop on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        buf_addr_q[k] <= '0;
        buf_r_q[k]    <= '0;
        buf_last_q[k] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        buf_addr_q[wr_ptr_q] <= agu_out_addr;
        buf_r_q[wr_ptr_q]    <= tag_r_q;
        buf_last_q[wr_ptr_q] <= tag_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign agu_i    = I_WIDTH'(i_q);
  assign agu_r    = r_q;
  assign agu_addr = ADDR_WIDTH'(w_q);

  assign out_addr = out_valid ? buf_addr_q[rd_ptr_q] : '0;
  assign out_r    = out_valid ? buf_r_q[rd_ptr_q] : '0;
  assign out_last = out_valid && buf_last_q[rd_ptr_q];
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef AUTOSEQ_STATS_EN
  logic [31:0] stall_q, beats_q;
  logic        active;

  assign active = (state_q == StRun) || (state_q == StDrain);

  // Saturating statistics, cleared on reset and on an accepted start
  always_ff @(posedge clk) begin
    if (rst || ((state_q == StIdle) && start)) begin
      stall_q <= '0;
      beats_q <= '0;
    end else begin
      if (active && out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (pop && (beats_q != 32'hFFFF_FFFF)) begin
        beats_q <= beats_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign beat_count   = beats_q;
`endif

endmodule

// File: tb/tb_automorph_addr_sequencer.sv
// Directed self-checking bench for automorph_addr_sequencer with a behavioural AGU.
module tb_automorph_addr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  cfg_num_rot;
  logic [15:0] cfg_num_i;
  logic [15:0] cfg_num_words;
  logic [31:0] agu_i;
  logic [4:0]  agu_r;
  logic [9:0]  agu_addr;
  logic [9:0]  agu_out_addr;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_addr;
  logic [4:0]  out_r;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef AUTOSEQ_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] beat_count;
`endif

  int errors = 0;
  int checks = 0;

  automorph_addr_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_num_rot   (cfg_num_rot),
    .cfg_num_i     (cfg_num_i),
    .cfg_num_words (cfg_num_words),
    .agu_i         (agu_i),
    .agu_r         (agu_r),
    .agu_addr      (agu_addr),
    .agu_out_addr  (agu_out_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
    .out_r         (out_r),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done)
`ifdef AUTOSEQ_STATS_EN
    ,
    .stall_cycles  (stall_cycles),
    .beat_count    (beat_count)
`endif
  );

  initial forever #5 clk = ~clk;

  // Stand-in AGU: r=0 passes w straight through; other rotations mix in i and r.
  function automatic logic [9:0] agu_model(input int unsigned i, input int unsigned r,
                                           input int unsigned w);
    int unsigned v;
    v = w + r * (8 * i + 64);
    return v[9:0];
  endfunction

  always @(posedge clk) agu_out_addr <= agu_model(agu_i, 32'(agu_r), 32'(agu_addr));

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    cfg_num_rot = 5'd0; cfg_num_i = 16'd0; cfg_num_words = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, done, out_last} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got valid/busy/done/last=%b, want 0000",
               {out_valid, busy, done, out_last});
    end
    checks++;
    if ({agu_i, agu_r, agu_addr} !== 47'd0) begin
      errors++;
      $display("FAIL reset_agu: got i=%0d r=%0d addr=%0d, want 0 0 0", agu_i, agu_r, agu_addr);
    end
    checks++;
    if ({out_addr, out_r} !== 15'd0) begin
      errors++;
      $display("FAIL reset_out: got addr=%0d r=%0d, want 0 0", out_addr, out_r);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Runs one batch, checking every beat, the AGU walk, busy, and the done timing.
  task automatic run_batch(input string name, input int nr, input int ni, input int nw,
                           input bit toggle, input int restart_at, input bit poke_done,
                           output int max_r);
    logic [9:0] exp_addr[$];
    logic [4:0] exp_r[$];
    logic       exp_last[$];
    int tr[$], ti[$], tw[$];
    int exp_n, k, cyc, first_valid, done_cyc, last_pop, idx, agu_bad, busy_bad;
    for (int r = 0; r < nr; r++)
      for (int i = 0; i < ni; i++)
        for (int w = 0; w < nw; w++) begin
          exp_addr.push_back(agu_model(i, r, w));
          exp_r.push_back(5'(r));
          exp_last.push_back((w == nw - 1) && (i == ni - 1));
          tr.push_back(r); ti.push_back(i); tw.push_back(w);
        end
    exp_n = nr * ni * nw;
    k = 0; first_valid = -1; done_cyc = -1; last_pop = -1;
    idx = 0; agu_bad = 0; busy_bad = 0; max_r = 0;
    @(posedge clk); #1;
    start = 1'b1; out_ready = 1'b1;
    cfg_num_rot = 5'(nr); cfg_num_i = 16'(ni); cfg_num_words = 16'(nw);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 2000) begin
      if (toggle) out_ready = (cyc % 2) == 1;
      if (cyc == restart_at) begin
        start = 1'b1; cfg_num_rot = 5'd1; cfg_num_i = 16'd5; cfg_num_words = 16'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (agu_i == 32'(ti[idx]) && agu_r == 5'(tr[idx]) && agu_addr == 10'(tw[idx])) begin
      end else if (idx + 1 < exp_n && agu_i == 32'(ti[idx+1]) && agu_r == 5'(tr[idx+1]) &&
                   agu_addr == 10'(tw[idx+1])) begin
        idx++;
      end else begin
        agu_bad++;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        checks++;
        if (k >= exp_n) begin
          errors++;
          $display("FAIL %s extra_beat %0d: got addr=%0d, want no beat", name, k, out_addr);
        end else if ({out_addr, out_r, out_last} !== {exp_addr[k], exp_r[k], exp_last[k]}) begin
          errors++;
          $display("FAIL %s beat %0d: got addr=%0d r=%0d last=%0b, want addr=%0d r=%0d last=%0b",
                   name, k, out_addr, out_r, out_last, exp_addr[k], exp_r[k], exp_last[k]);
        end
        if (int'(out_r) > max_r) max_r = int'(out_r);
        k++;
        last_pop = cyc;
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        if (busy !== 1'b0) busy_bad++;
        if (poke_done) start = 1'b1;
      end else if (busy !== 1'b1) begin
        busy_bad++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (k !== exp_n) begin
      errors++;
      $display("FAIL %s beat_count: got %0d, want %0d", name, k, exp_n);
    end
    checks++;
    if (done_cyc < 0 || done_cyc !== last_pop + 1) begin
      errors++;
      $display("FAIL %s done_timing: got cycle %0d, want %0d", name, done_cyc, last_pop + 1);
    end
    checks++;
    if (first_valid !== 3) begin
      errors++;
      $display("FAIL %s first_valid: got cycle %0d, want 3", name, first_valid);
    end
    checks++;
    if (agu_bad !== 0 || idx !== exp_n - 1) begin
      errors++;
      $display("FAIL %s agu_walk: got %0d bad steps, last index %0d, want 0 and %0d",
               name, agu_bad, idx, exp_n - 1);
    end
    checks++;
    if (busy_bad !== 0) begin
      errors++;
      $display("FAIL %s busy: got %0d bad cycles, want 0", name, busy_bad);
    end
    if (!toggle) begin
      checks++;
      if (last_pop !== first_valid + exp_n - 1) begin
        errors++;
        $display("FAIL %s throughput: got last beat at %0d, want %0d",
                 name, last_pop, first_valid + exp_n - 1);
      end
    end
    @(negedge clk);
    checks++;
    if ({done, busy, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL %s after_done: got done/busy/valid=%b, want 000", name, {done, busy, out_valid});
    end
  endtask

  task automatic test_full_stream();
    int mr;
    run_batch("full", 2, 3, 4, 1'b0, -1, 1'b1, mr);
`ifdef AUTOSEQ_STATS_EN
    checks++;
    if (beat_count !== 32'd24 || stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL stats: got beats=%0d stalls=%0d, want 24 0", beat_count, stall_cycles);
    end
`endif
    // A start pulsed during the DONE cycle must not launch a batch
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL start_in_done: got busy=%0b, want 0", busy);
      end
    end
  endtask

  task automatic test_backpressure();
    int mr;
    run_batch("toggle", 2, 3, 4, 1'b1, -1, 1'b0, mr);
  endtask

  task automatic test_identity();
    int mr;
    run_batch("identity", 1, 2, 2, 1'b0, -1, 1'b0, mr);
  endtask

  task automatic test_zero_cfg();
    int seen_valid;
    seen_valid = 0;
    @(posedge clk); #1;
    start = 1'b1; cfg_num_rot = 5'd2; cfg_num_i = 16'd0; cfg_num_words = 16'd4;
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    if (out_valid) seen_valid++;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL zero_t1: got busy/done=%b, want 10", {busy, done});
    end
    @(posedge clk); #1;
    @(negedge clk);
    if (out_valid) seen_valid++;
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL zero_t2: got busy/done=%b, want 01", {busy, done});
    end
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (out_valid || done || busy) seen_valid++;
    end
    checks++;
    if (seen_valid !== 0) begin
      errors++;
      $display("FAIL zero_quiet: got %0d active cycles, want 0", seen_valid);
    end
  endtask

  task automatic test_mid_reset();
    int k, cyc, bad;
    k = 0; cyc = 0; bad = 0;
    @(posedge clk); #1;
    start = 1'b1; out_ready = 1'b1;
    cfg_num_rot = 5'd2; cfg_num_i = 16'd3; cfg_num_words = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    while (k < 5 && cyc < 50) begin
      @(negedge clk);
      if (out_valid && out_ready) k++;
      if (k < 5) begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    checks++;
    if (k !== 5) begin
      errors++;
      $display("FAIL midrst_reach: got %0d beats, want 5", k);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_abort: got valid/busy/done=%b, want 000", {out_valid, busy, done});
    end
    repeat (8) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (out_valid || busy || done) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midrst_quiet: got %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_restart_ignored();
    int mr;
    run_batch("rot31", 31, 1, 2, 1'b0, 10, 1'b0, mr);
    checks++;
    if (mr !== 30) begin
      errors++;
      $display("FAIL rot31_max_r: got %0d, want 30", mr);
    end
  endtask

  initial begin
    int mr;
    test_reset();
    test_full_stream();
    test_backpressure();
    test_identity();
    test_zero_cfg();
    test_mid_reset();
    run_batch("after_rst", 2, 3, 4, 1'b0, -1, 1'b0, mr);
    test_restart_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
